// File: rtl/ds_frame_ctrl_pkg.sv
// Shared constants, types and helpers for the down_scale frame controller.
package ds_ctrl_pkg;

   localparam int unsigned CAMSIZEX = 640;
   localparam int unsigned MW       = 3;
   localparam int unsigned BPP      = 10;
   localparam int unsigned FCW      = 16;
   localparam int unsigned WW       = 3;
   localparam int unsigned CW       = $clog2(CAMSIZEX + 1);
   localparam int unsigned LCW      = 16;
   localparam int unsigned PCW      = 32;

   typedef logic [BPP-1:0] pixel_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOF = 2'd1,
      ST_ACTIVE   = 2'd2,
      ST_DRAIN    = 2'd3
   } state_e;

   typedef struct packed {
      logic [MW-1:0] mode;
      logic [WW-1:0] weight;
   } ds_cfg_t;

   // Output pixels per line that down_scale produces for a given mode
   function automatic logic [CW-1:0] exp_width(input logic [MW-1:0] mode);
      return CW'(CAMSIZEX >> mode);
   endfunction

endpackage

// File: rtl/ds_frame_ctrl_if.sv
// Camera-in, down_scale-out and down_scale-monitor signal bundle.
interface ds_frame_ctrl_if;
   import ds_ctrl_pkg::*;

   logic          i_frame_valid;
   logic          i_line_valid;
   logic          i_pixel_valid;
   logic          ds_frame_valid;
   logic          ds_line_valid;
   logic          ds_pixel_valid;
   logic [MW-1:0] ds_mode;
   logic [WW-1:0] ds_weight;
   logic          mon_frame_valid;
   logic          mon_line_valid;
   logic          mon_pixel_valid;

   modport master (
      input  i_frame_valid, i_line_valid, i_pixel_valid,
      input  mon_frame_valid, mon_line_valid, mon_pixel_valid,
      output ds_frame_valid, ds_line_valid, ds_pixel_valid, ds_mode, ds_weight
   );

   modport slave (
      output i_frame_valid, i_line_valid, i_pixel_valid,
      output mon_frame_valid, mon_line_valid, mon_pixel_valid,
      input  ds_frame_valid, ds_line_valid, ds_pixel_valid, ds_mode, ds_weight
   );

endinterface

// File: rtl/ds_frame_ctrl_line_checker.sv
// Counts down_scale output pixels per line and flags lines whose width
// differs from the width implied by the active mode (sticky error).
module ds_line_checker
   import ds_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [MW-1:0] i_mode,
   input  logic          i_line_valid,
   input  logic          i_pixel_valid,
   input  logic          i_err_clr,
   output logic          o_err_width
);

   logic          r_lv_d;
   logic [CW-1:0] r_cnt;
   logic          r_err;
   logic          w_line_end;
   logic          w_mismatch;

   assign w_line_end = ~i_line_valid & r_lv_d;
   assign w_mismatch = w_line_end & (r_cnt != exp_width(i_mode));

   // Saturating per-line pixel counter, cleared at end of line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lv_d <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_lv_d <= i_line_valid;
         if (w_line_end)
            r_cnt <= '0;
         else if (i_line_valid && i_pixel_valid && !(&r_cnt))
            r_cnt <= r_cnt + CW'(1);
      end
   end

   // A new mismatch outranks a simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err <= 1'b0;
      else if (w_mismatch)
         r_err <= 1'b1;
      else if (i_err_clr)
         r_err <= 1'b0;
   end

   assign o_err_width = r_err;

endmodule

// File: rtl/ds_frame_ctrl.sv
// Frame-level sequencer for the down_scale stage: whole-frame gating, between-frame
// config shadowing, completion tracking. DS_STATS_EN adds per-frame line/pixel stats.
module ds_frame_ctrl
   import ds_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             cfg_wr,
   input  logic [MW-1:0]    cfg_mode,
   input  logic [WW-1:0]    cfg_weight,
   input  logic             err_clr,
   ds_frame_ctrl_if.master  bus,
   output logic             busy,
   output logic             frame_done,
   output logic [FCW-1:0]   frame_cnt,
`ifdef DS_STATS_EN
   output logic [LCW-1:0]   line_cnt,
   output logic [PCW-1:0]   pix_cnt,
`endif
   output logic             err_width
);

   localparam logic [1:0] S_IDLE     = 2'(ST_IDLE);
   localparam logic [1:0] S_WAIT_SOF = 2'(ST_WAIT_SOF);
   localparam logic [1:0] S_ACTIVE   = 2'(ST_ACTIVE);
   localparam logic [1:0] S_DRAIN    = 2'(ST_DRAIN);

   logic [1:0]     r_state;
   logic [1:0]     w_state_nxt;
   logic           r_fv_d;
   logic           r_gate;
   logic           r_mon_seen;
   ds_cfg_t        r_pend;
   ds_cfg_t        r_act;
   logic           r_busy;
   logic           r_frame_done;
   logic [FCW-1:0] r_frame_cnt;

   logic           w_sof;
   logic           w_fall;
   logic           w_start;
   logic           w_done;
   logic           w_gate;
   logic           w_in_frame;

   assign w_sof      = bus.i_frame_valid & ~r_fv_d;
   assign w_fall     = ~bus.i_frame_valid & r_fv_d;
   assign w_in_frame = (r_state == S_ACTIVE) || (r_state == S_DRAIN);

   // Next-state logic; start/done are single-cycle transition strobes
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable && !bus.i_frame_valid)
               w_state_nxt = S_WAIT_SOF;
         end
         S_WAIT_SOF: begin
            if (!enable) begin
               w_state_nxt = S_IDLE;
            end else if (w_sof) begin
               w_state_nxt = S_ACTIVE;
               w_start     = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (w_fall)
               w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_mon_seen && !bus.mon_frame_valid) begin
               w_done      = 1'b1;
               w_state_nxt = enable ? S_WAIT_SOF : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_fv_d       <= 1'b0;
         r_gate       <= 1'b0;
         r_mon_seen   <= 1'b0;
         r_pend       <= '0;
         r_act        <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fv_d  <= bus.i_frame_valid;

         if (w_fall)
            r_gate <= 1'b0;
         else if (w_start)
            r_gate <= 1'b1;

         if (cfg_wr)
            r_pend <= '{mode: cfg_mode, weight: cfg_weight};

         // Active config only tracks pending while no frame is in flight
         if (!w_in_frame)
            r_act <= r_pend;

         if (w_start || w_done)
            r_mon_seen <= 1'b0;
         else if (w_in_frame && bus.mon_frame_valid)
            r_mon_seen <= 1'b1;

         r_busy       <= (w_state_nxt == S_ACTIVE) || (w_state_nxt == S_DRAIN);
         r_frame_done <= w_done;
         if (w_done)
            r_frame_cnt <= r_frame_cnt + FCW'(1);
      end
   end

   // Gate opens in the SOF cycle itself so the first beat of the frame is not lost
   assign w_gate             = r_gate | w_start;
   assign bus.ds_frame_valid = bus.i_frame_valid & w_gate;
   assign bus.ds_line_valid  = bus.i_line_valid  & w_gate;
   assign bus.ds_pixel_valid = bus.i_pixel_valid & w_gate;
   assign bus.ds_mode        = r_act.mode;
   assign bus.ds_weight      = r_act.weight;

   assign busy       = r_busy;
   assign frame_done = r_frame_done;
   assign frame_cnt  = r_frame_cnt;

   ds_line_checker u_line_checker (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_mode        (r_act.mode),
      .i_line_valid  (bus.mon_line_valid),
      .i_pixel_valid (bus.mon_pixel_valid),
      .i_err_clr     (err_clr),
      .o_err_width   (err_width)
   );

`ifdef DS_STATS_EN
   logic           r_mlv_d;
   logic [LCW-1:0] r_line_run;
   logic [LCW-1:0] r_line_cnt;
   logic [PCW-1:0] r_pix_run;
   logic [PCW-1:0] r_pix_cnt;
   logic           w_mline_end;

   assign w_mline_end = ~bus.mon_line_valid & r_mlv_d;

   // Running counts restart at SOF; snapshot includes any event in the done cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mlv_d    <= 1'b0;
         r_line_run <= '0;
         r_line_cnt <= '0;
         r_pix_run  <= '0;
         r_pix_cnt  <= '0;
      end else begin
         r_mlv_d <= bus.mon_line_valid;
         if (w_sof) begin
            r_line_run <= '0;
            r_pix_run  <= '0;
         end else begin
            if (w_mline_end)
               r_line_run <= r_line_run + LCW'(1);
            if (bus.mon_pixel_valid)
               r_pix_run <= r_pix_run + PCW'(1);
         end
         if (w_done) begin
            r_line_cnt <= r_line_run + LCW'(w_mline_end);
            r_pix_cnt  <= r_pix_run + PCW'(bus.mon_pixel_valid);
         end
      end
   end

   assign line_cnt = r_line_cnt;
   assign pix_cnt  = r_pix_cnt;
`endif

endmodule

// File: tb/tb_ds_frame_ctrl.sv
// Directed bench for ds_frame_ctrl: camera and down_scale output are driven as vectors.
module tb_ds_frame_ctrl;
   import ds_ctrl_pkg::*;

   logic           clk;
   logic           rst_n;
   logic           enable;
   logic           cfg_wr;
   logic [MW-1:0]  cfg_mode;
   logic [WW-1:0]  cfg_weight;
   logic           err_clr;
   logic           busy;
   logic           frame_done;
   logic [FCW-1:0] frame_cnt;
   logic           err_width;
`ifdef DS_STATS_EN
   logic [LCW-1:0] line_cnt;
   logic [PCW-1:0] pix_cnt;
`endif

   int checks;
   int errors;

   ds_frame_ctrl_if bus ();

   ds_frame_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .cfg_wr     (cfg_wr),
      .cfg_mode   (cfg_mode),
      .cfg_weight (cfg_weight),
      .err_clr    (err_clr),
      .bus        (bus),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
`ifdef DS_STATS_EN
      .line_cnt   (line_cnt),
      .pix_cnt    (pix_cnt),
`endif
      .err_width  (err_width)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Camera frame; optional cfg write / enable change in the gap before a given line
   task automatic cam_frame(input int lines, input int pix, input int wr_line,
                            input logic [2:0] wmode, input logic [2:0] wweight,
                            input int en_line, input logic en_val,
                            input logic [2:0] exp_mode, output int gated);
      gated = 0;
      bus.i_frame_valid = 1'b1;
      step();
      for (int l = 0; l < lines; l++) begin
         if (l == wr_line) begin
            cfg_wr = 1'b1; cfg_mode = wmode; cfg_weight = wweight;
         end
         if (l == en_line) enable = en_val;
         step();
         cfg_wr = 1'b0;
         bus.i_line_valid = 1'b1;
         bus.i_pixel_valid = 1'b1;
         for (int p = 0; p < pix; p++) begin
            #1;
            if (bus.ds_pixel_valid === 1'b1) gated++;
            step();
         end
         bus.i_line_valid = 1'b0;
         bus.i_pixel_valid = 1'b0;
         checks++;
         if (bus.ds_mode !== exp_mode) begin
            errors++;
            $display("FAIL cam_ds_mode line %0d: got %0d want %0d", l, bus.ds_mode, exp_mode);
         end
      end
      step();
      bus.i_frame_valid = 1'b0;
      step();
      step();
   endtask

   // down_scale output frame; checks the frame_done pulse and count
   task automatic mon_frame(input int lines, input int width, input int short_line, input int exp_cnt);
      int w;
      bus.mon_frame_valid = 1'b1;
      step();
      for (int l = 0; l < lines; l++) begin
         w = (l == short_line) ? width - 1 : width;
         bus.mon_line_valid = 1'b1;
         bus.mon_pixel_valid = 1'b1;
         for (int p = 0; p < w; p++) step();
         bus.mon_line_valid = 1'b0;
         bus.mon_pixel_valid = 1'b0;
         step();
      end
      bus.mon_frame_valid = 1'b0;
      step();
      checks++;
      if (frame_done !== 1'b1) begin
         errors++; $display("FAIL frame_done_pulse: got %0b want 1", frame_done);
      end
      checks++;
      if (frame_cnt !== 16'(exp_cnt)) begin
         errors++; $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, exp_cnt);
      end
      step();
      checks++;
      if (frame_done !== 1'b0) begin
         errors++; $display("FAIL frame_done_single: got %0b want 0", frame_done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_frame_valid = 1'b1; bus.i_line_valid = 1'b1; bus.i_pixel_valid = 1'b1;
      repeat (3) step();
      checks++;
      if ({bus.ds_frame_valid, bus.ds_line_valid, bus.ds_pixel_valid} !== 3'b000) begin
         errors++; $display("FAIL reset_ds_valid: got %b want 000",
                            {bus.ds_frame_valid, bus.ds_line_valid, bus.ds_pixel_valid});
      end
      checks++;
      if ({busy, frame_done, err_width} !== 3'b000) begin
         errors++; $display("FAIL reset_status: got %b want 000", {busy, frame_done, err_width});
      end
      checks++;
      if (frame_cnt !== 16'd0 || bus.ds_mode !== 3'd0 || bus.ds_weight !== 3'd0) begin
         errors++; $display("FAIL reset_regs: cnt %0d mode %0d weight %0d want 0 0 0",
                            frame_cnt, bus.ds_mode, bus.ds_weight);
      end
      bus.i_frame_valid = 1'b0; bus.i_line_valid = 1'b0; bus.i_pixel_valid = 1'b0;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int g;
      cfg_wr = 1'b1; cfg_mode = 3'd1; cfg_weight = 3'd3;
      step();
      cfg_wr = 1'b0;
      enable = 1'b1;
      step(); step();
      checks++;
      if (bus.ds_mode !== 3'd1 || bus.ds_weight !== 3'd3) begin
         errors++; $display("FAIL basic_cfg_apply: mode %0d weight %0d want 1 3", bus.ds_mode, bus.ds_weight);
      end
      cam_frame(4, 640, -1, 3'd0, 3'd0, -1, 1'b0, 3'd1, g);
      checks++;
      if (g !== 2560) begin errors++; $display("FAIL basic_gated: got %0d want 2560", g); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_drain: got %0b want 1", busy); end
      mon_frame(4, 320, -1, 1);
      checks++;
      if (err_width !== 1'b0) begin errors++; $display("FAIL basic_err: got %0b want 0", err_width); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %0b want 0", busy); end
   endtask

   task automatic test_shadow();
      int g;
      cam_frame(4, 640, 1, 3'd2, 3'd5, -1, 1'b0, 3'd1, g);
      checks++;
      if (g !== 2560) begin errors++; $display("FAIL shadow_gated: got %0d want 2560", g); end
      checks++;
      if (bus.ds_mode !== 3'd1) begin errors++; $display("FAIL shadow_drain_mode: got %0d want 1", bus.ds_mode); end
      mon_frame(4, 320, -1, 2);
      step();
      checks++;
      if (bus.ds_mode !== 3'd2 || bus.ds_weight !== 3'd5) begin
         errors++; $display("FAIL shadow_next_cfg: mode %0d weight %0d want 2 5", bus.ds_mode, bus.ds_weight);
      end
      checks++;
      if (err_width !== 1'b0) begin errors++; $display("FAIL shadow_err1: got %0b want 0", err_width); end
      cam_frame(4, 640, -1, 3'd0, 3'd0, -1, 1'b0, 3'd2, g);
      mon_frame(4, 160, -1, 3);
      checks++;
      if (err_width !== 1'b0) begin errors++; $display("FAIL shadow_err2: got %0b want 0", err_width); end
   endtask

   task automatic test_enable_midframe();
      int g;
      enable = 1'b0;
      step(); step();
      cam_frame(4, 640, -1, 3'd0, 3'd0, 0, 1'b1, 3'd2, g);
      checks++;
      if (g !== 0) begin errors++; $display("FAIL midframe_blocked: got %0d want 0", g); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midframe_busy: got %0b want 0", busy); end
      cam_frame(4, 640, -1, 3'd0, 3'd0, -1, 1'b0, 3'd2, g);
      checks++;
      if (g !== 2560) begin errors++; $display("FAIL midframe_next: got %0d want 2560", g); end
      mon_frame(4, 160, -1, 4);
   endtask

   task automatic test_width_err();
      int g;
      cfg_wr = 1'b1; cfg_mode = 3'd1; cfg_weight = 3'd0;
      step();
      cfg_wr = 1'b0;
      step(); step();
      cam_frame(2, 640, -1, 3'd0, 3'd0, -1, 1'b0, 3'd1, g);
      mon_frame(2, 320, 1, 5);
      checks++;
      if (err_width !== 1'b1) begin errors++; $display("FAIL width_set: got %0b want 1", err_width); end
      cam_frame(2, 640, -1, 3'd0, 3'd0, -1, 1'b0, 3'd1, g);
      mon_frame(2, 320, -1, 6);
      checks++;
      if (err_width !== 1'b1) begin errors++; $display("FAIL width_sticky: got %0b want 1", err_width); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checks++;
      if (err_width !== 1'b0) begin errors++; $display("FAIL width_clr: got %0b want 0", err_width); end
      bus.mon_line_valid = 1'b1; bus.mon_pixel_valid = 1'b1;
      repeat (319) step();
      bus.mon_line_valid = 1'b0; bus.mon_pixel_valid = 1'b0; err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checks++;
      if (err_width !== 1'b1) begin errors++; $display("FAIL width_set_wins: got %0b want 1", err_width); end
      err_clr = 1'b1;
      cfg_wr = 1'b1; cfg_mode = 3'd0; cfg_weight = 3'd0;
      step();
      err_clr = 1'b0; cfg_wr = 1'b0;
      step(); step();
      bus.mon_line_valid = 1'b1; bus.mon_pixel_valid = 1'b1;
      repeat (640) step();
      bus.mon_line_valid = 1'b0; bus.mon_pixel_valid = 1'b0;
      step();
      checks++;
      if (err_width !== 1'b0 || bus.ds_mode !== 3'd0) begin
         errors++; $display("FAIL width_bypass: err %0b mode %0d want 0 0", err_width, bus.ds_mode);
      end
   endtask

   task automatic test_enable_drop();
      int g;
      cam_frame(2, 640, -1, 3'd0, 3'd0, 1, 1'b0, 3'd0, g);
      checks++;
      if (g !== 1280) begin errors++; $display("FAIL drop_gated: got %0d want 1280", g); end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy: got %0b want 1", busy); end
      mon_frame(2, 640, -1, 7);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got %0b want 0", busy); end
      cam_frame(2, 640, -1, 3'd0, 3'd0, -1, 1'b0, 3'd0, g);
      checks++;
      if (g !== 0 || frame_cnt !== 16'd7) begin
         errors++; $display("FAIL drop_blocked: gated %0d cnt %0d want 0 7", g, frame_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      int g;
      bus.mon_line_valid = 1'b1; bus.mon_pixel_valid = 1'b1;
      repeat (5) step();
      bus.mon_line_valid = 1'b0; bus.mon_pixel_valid = 1'b0;
      enable = 1'b1;
      step(); step();
      checks++;
      if (err_width !== 1'b1) begin errors++; $display("FAIL rstmid_pre_err: got %0b want 1", err_width); end
      bus.i_frame_valid = 1'b1;
      step(); step();
      bus.i_line_valid = 1'b1; bus.i_pixel_valid = 1'b1;
      #1;
      checks++;
      if (bus.ds_pixel_valid !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre_gate: got %0b want 1", bus.ds_pixel_valid);
      end
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.ds_pixel_valid, busy, err_width} !== 3'b000 || frame_cnt !== 16'd0) begin
         errors++; $display("FAIL rstmid_async: pv/busy/err %b cnt %0d want 000 0",
                            {bus.ds_pixel_valid, busy, err_width}, frame_cnt);
      end
      step();
      rst_n = 1'b1;
      g = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus.ds_pixel_valid === 1'b1) g++;
         step();
      end
      checks++;
      if (g !== 0) begin errors++; $display("FAIL rstmid_remainder: got %0d want 0", g); end
      bus.i_line_valid = 1'b0; bus.i_pixel_valid = 1'b0;
      step();
      bus.i_frame_valid = 1'b0;
      step(); step(); step();
      cam_frame(1, 8, -1, 3'd0, 3'd0, -1, 1'b0, 3'd0, g);
      checks++;
      if (g !== 8) begin errors++; $display("FAIL rstmid_next_frame: got %0d want 8", g); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      enable = 1'b0;
      cfg_wr = 1'b0;
      cfg_mode = '0;
      cfg_weight = '0;
      err_clr = 1'b0;
      bus.i_frame_valid = 1'b0;
      bus.i_line_valid = 1'b0;
      bus.i_pixel_valid = 1'b0;
      bus.mon_frame_valid = 1'b0;
      bus.mon_line_valid = 1'b0;
      bus.mon_pixel_valid = 1'b0;

      test_reset();
      test_basic();
      test_shadow();
      test_enable_midframe();
      test_width_err();
      test_enable_drop();
      test_reset_midframe();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
